// File: rtl/uart_pkg.sv
// Shared UART types: parity selection, one-hot TX frame states and the minimum data width.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_RSVD = 2'd3
  } parity_e;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } tx_state_e;

  localparam int DATA_BITS_MIN = 5;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: counts 0..max(div,1)-1, held at zero while restart is high.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;

  // A divider of zero behaves exactly like a divider of one.
  assign last     = (div == '0) ? '0 : div - DIV_W'(1);
  assign bit_tick = !restart && (cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with runtime data width, parity and stop-bit selection and a baud divider.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int DIV_W  = 16
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic [DIV_W-1:0]  clks_per_bit_i,
  input  logic [3:0]        data_bits_i,
  input  logic [1:0]        parity_i,
  input  logic              stop2_i,
  output logic              tx_busy_o,
  output logic              tx_done_o,
  output logic              uart_tx_o
);

  localparam logic [3:0] MAX_BITS = 4'(DATA_W);
  localparam logic [3:0] MIN_BITS = 4'(DATA_BITS_MIN);

  function automatic logic [3:0] clamp_bits(input logic [3:0] b);
    return ((b < MIN_BITS) || (b > MAX_BITS)) ? MAX_BITS : b;
  endfunction

  function automatic logic [DATA_W-1:0] mask_data(input logic [DATA_W-1:0] d,
                                                  input logic [3:0]        b);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < DATA_W; i++) m[i] = d[i] && (i < int'(b));
    return m;
  endfunction

  tx_state_e         state;
  logic [DATA_W-1:0] shift_reg;
  logic [3:0]        bit_cnt;
  logic [3:0]        nbits;
  logic              par_en;
  logic              par_bit;
  logic              stop2;
  logic [DIV_W-1:0]  div_q;
  logic              bit_tick;

  logic [3:0]        cap_bits;
  logic [DATA_W-1:0] cap_data;
  parity_e           cap_par;

  always_comb begin
    cap_bits = clamp_bits(data_bits_i);
    cap_data = mask_data(tx_data_i, cap_bits);
    cap_par  = parity_e'(parity_i);
  end

  assign tx_ready_o = (state == ST_IDLE);
  assign tx_busy_o  = !tx_ready_o;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk_i),
    .rst_n    (resetn_i),
    .restart  (tx_ready_o),
    .div      (div_q),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state     <= ST_IDLE;
      uart_tx_o <= 1'b1;
      tx_done_o <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      nbits     <= MAX_BITS;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      stop2     <= 1'b0;
      div_q     <= '0;
    end else begin
      tx_done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          uart_tx_o <= 1'b1;
          if (tx_valid_i) begin
            shift_reg <= cap_data;
            nbits     <= cap_bits;
            par_en    <= (cap_par == PAR_EVEN) || (cap_par == PAR_ODD);
            par_bit   <= (^cap_data) ^ (cap_par == PAR_ODD);
            stop2     <= stop2_i;
            div_q     <= clks_per_bit_i;
            bit_cnt   <= '0;
            uart_tx_o <= 1'b0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            uart_tx_o <= shift_reg[0];
            bit_cnt   <= '0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_cnt == nbits - 4'd1) begin
              bit_cnt <= '0;
              if (par_en) begin
                uart_tx_o <= par_bit;
                state     <= ST_PARITY;
              end else begin
                uart_tx_o <= 1'b1;
                state     <= ST_STOP;
              end
            end else begin
              bit_cnt   <= bit_cnt + 4'd1;
              shift_reg <= shift_reg >> 1;
              uart_tx_o <= shift_reg[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            uart_tx_o <= 1'b1;
            bit_cnt   <= '0;
            state     <= ST_STOP;
          end
        end
        ST_STOP: begin
          uart_tx_o <= 1'b1;
          if (bit_tick) begin
            if (stop2 && (bit_cnt == 4'd0)) begin
              bit_cnt <= 4'd1;
            end else begin
              tx_done_o <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end
        default: begin
          uart_tx_o <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: line waveform per cycle against hand-derived frames.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        resetn_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [8:0]  tx_data_i;
  logic [15:0] clks_per_bit_i;
  logic [3:0]  data_bits_i;
  logic [1:0]  parity_i;
  logic        stop2_i;
  logic        tx_busy_o;
  logic        tx_done_o;
  logic        uart_tx_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_W(9), .DIV_W(16)) dut (
    .clk_i          (clk),
    .resetn_i       (resetn_i),
    .tx_valid_i     (tx_valid_i),
    .tx_ready_o     (tx_ready_o),
    .tx_data_i      (tx_data_i),
    .clks_per_bit_i (clks_per_bit_i),
    .data_bits_i    (data_bits_i),
    .parity_i       (parity_i),
    .stop2_i        (stop2_i),
    .tx_busy_o      (tx_busy_o),
    .tx_done_o      (tx_done_o),
    .uart_tx_o      (uart_tx_o)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the first frame cycle.
  task automatic start_frame(input logic [8:0] data, input logic [15:0] cpb,
                             input logic [3:0] dbits, input logic [1:0] par, input logic s2);
    tx_data_i      = data;
    clks_per_bit_i = cpb;
    data_bits_i    = dbits;
    parity_i       = par;
    stop2_i        = s2;
    tx_valid_i     = 1'b1;
    chk("ready_before_transfer", {15'd0, tx_ready_o}, 16'd1);
    @(posedge clk);
    @(negedge clk);
    tx_valid_i     = 1'b0;
    tx_data_i      = ~data;
    clks_per_bit_i = cpb + 16'd5;
    data_bits_i    = 4'd6;
    parity_i       = 2'd2;
    stop2_i        = ~s2;
  endtask

  // exp[i] is the i-th line bit of the frame (start first); each lasts n cycles.
  task automatic check_frame(input string tag, input logic [15:0] exp, input int len, input int n);
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < n; c++) begin
        chk($sformatf("%s_bit%0d_cyc%0d", tag, i, c), {13'd0, tx_busy_o, tx_done_o, uart_tx_o},
            {13'd0, 1'b1, 1'b0, exp[i]});
        @(negedge clk);
      end
    end
    chk({tag, "_done"}, {12'd0, tx_busy_o, tx_done_o, tx_ready_o, uart_tx_o}, 16'b0111);
  endtask

  initial begin
    resetn_i       = 1'b0;
    tx_valid_i     = 1'b0;
    tx_data_i      = '0;
    clks_per_bit_i = 16'd1;
    data_bits_i    = 4'd8;
    parity_i       = 2'd0;
    stop2_i        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {12'd0, tx_busy_o, tx_done_o, tx_ready_o, uart_tx_o}, 16'b0011);
    resetn_i = 1'b1;
    @(negedge clk);
    chk("idle_after_release", {12'd0, tx_busy_o, tx_done_o, tx_ready_o, uart_tx_o}, 16'b0011);

    // 8N1, N=4, 0x55: 0,1,0,1,0,1,0,1,0,1
    start_frame(9'h055, 16'd4, 4'd8, 2'd0, 1'b0);
    check_frame("8n1_55", 16'h02AA, 10, 4);

    // 7E2, N=3, 0x41: 0,1000001,0,1,1
    start_frame(9'h041, 16'd3, 4'd7, 2'd1, 1'b1);
    check_frame("7e2_41", 16'h0682, 11, 3);

    // 5O1, N=1, 0x1F: 0,11111,0,1
    start_frame(9'h01F, 16'd1, 4'd5, 2'd2, 1'b0);
    check_frame("5o1_1f", 16'h00BE, 8, 1);

    // Upper bits must not reach the data or the parity
    start_frame(9'h0FF, 16'd1, 4'd5, 2'd2, 1'b0);
    check_frame("5o1_ff", 16'h00BE, 8, 1);

    // Divider 0 behaves as 1
    start_frame(9'h01F, 16'd0, 4'd5, 2'd2, 1'b0);
    check_frame("5o1_div0", 16'h00BE, 8, 1);

    // data_bits=12 clamps to 9, parity code 3 means none: 0,101001011,1
    start_frame(9'h1A5, 16'd2, 4'd12, 2'd3, 1'b0);
    check_frame("9n1_clamp", 16'h074A, 11, 2);

    // Back-to-back with valid held; config changed mid-frame applies only to the next word
    tx_data_i      = 9'h0A5;
    clks_per_bit_i = 16'd2;
    data_bits_i    = 4'd8;
    parity_i       = 2'd0;
    stop2_i        = 1'b0;
    tx_valid_i     = 1'b1;
    chk("b2b_ready", {15'd0, tx_ready_o}, 16'd1);
    @(posedge clk);
    @(negedge clk);
    tx_data_i = 9'h03C;
    parity_i  = 2'd1;
    check_frame("b2b_a5", 16'h034A, 10, 2);
    @(posedge clk);
    @(negedge clk);
    tx_valid_i = 1'b0;
    check_frame("b2b_3c", 16'h0478, 11, 2);

    // Reset in the middle of the data bits
    start_frame(9'h055, 16'd4, 4'd8, 2'd0, 1'b0);
    repeat (9) @(negedge clk);
    chk("mid_frame_line", {15'd0, uart_tx_o}, 16'd0);
    resetn_i = 1'b0;
    #1;
    chk("async_reset_line", {12'd0, tx_busy_o, tx_done_o, tx_ready_o, uart_tx_o}, 16'b0011);
    @(negedge clk);
    resetn_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("no_done_after_reset%0d", k),
          {12'd0, tx_busy_o, tx_done_o, tx_ready_o, uart_tx_o}, 16'b0011);
      @(negedge clk);
    end
    start_frame(9'h041, 16'd3, 4'd7, 2'd1, 1'b1);
    check_frame("after_reset_7e2", 16'h0682, 11, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
